uart_tx_feeder: RTL
===================

# uart_tx_feeder

Byte-buffering front end for the UART transmit path. Sits directly upstream of the bit-index sequencer. Accepts bytes from the host into a small FIFO, presents one byte at a time on `tx_data`, and drives `tx_en` so the sequencer frames it. Uses the sequencer's `busy`/`done` outputs to detect frame start and frame end.

## Interface
Parameters:
- `DATA_WIDTH`, 8 — payload bits per frame.
- `DEPTH`, 4 — FIFO entries; must be a power of two.
- `ADDR_WIDTH`, 2 — log2(`DEPTH`).

Ports:
- `clk` input 1 — single clock; all logic is rising-edge.
- `arst_n` input 1 — asynchronous, active-low reset.
- `rst` input 1 — synchronous clear; same effect as `arst_n`, takes effect at the next edge.
- `wr_en` input 1 — host write strobe, one byte per cycle.
- `wr_data` input `DATA_WIDTH` — host byte.
- `tx_busy` input 1 — sequencer `busy`.
- `tx_done` input 1 — sequencer `done`.
- `tx_en` output 1 — enable to the sequencer; registered.
- `tx_data` output `DATA_WIDTH` — byte being framed; registered, stable for the whole frame.
- `full` output 1 — FIFO holds `DEPTH` entries.
- `empty` output 1 — FIFO holds 0 entries.
- `count` output `ADDR_WIDTH+1` — current occupancy.
- `overflow` output 1 — sticky; set when a write is dropped.

## Operation
- Reset (async or `rst`) sets:
  - `tx_en`=0, `tx_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0.
  - Both pointers = 0; state = IDLE.
- FIFO:
  - Pointers are `ADDR_WIDTH` bits and wrap naturally.
  - `count` is updated in the same edge as the pointers; `full`/`empty` are decoded from the registered `count`.
  - Write when `full` with no pop in the same cycle: the byte is dropped and `overflow` is set. `overflow` clears only on reset.
  - Write and pop in the same cycle: both occur, and `count` is unchanged. This applies when full too: that write is accepted.
  - There is no fall-through; a written byte can be popped at the earliest in the following cycle.
- State machine:
  - **IDLE** (`tx_en`=0): if `~empty`, then `tx_data` <= head, pop, `tx_en` <= 1, go to ARM.
  - **ARM** (`tx_en`=1): wait for `tx_busy`=1, which means the sequencer has taken its first bit tick; then go to SEND.
  - **SEND** (`tx_en`=1): frame end = rising edge of `tx_done`, i.e. registered `done_q`=0 and `tx_done`=1. At frame end:
    - Back-to-back case (see Configuration, requires `~empty`): `tx_data` <= head, pop, stay `tx_en`=1, go to ARM.
    - Otherwise: `tx_en` <= 0, go to IDLE.
- `done_q` resets to 1, which matches the sequencer's reset value of `done`.
- `tx_data` never changes while in ARM or SEND, except on the frame-end edge.
- Reset mid-frame: `tx_en` drops and the in-flight byte is lost. FIFO contents are discarded.

## Timing
- Write to `tx_en` rise: 2 cycles when the FIFO was empty and state was IDLE. Write at edge N, `count`=1 after N, pop and `tx_en`=1 after edge N+1.
- Frame end to `tx_en` fall: 1 cycle after the edge where `tx_done` rises.
- Back-to-back: `tx_en` stays high with no gap. New `tx_data` is valid in the same cycle the sequencer index has wrapped to 0.
- Non-back-to-back: `tx_en` is low for at least 1 cycle between frames, which returns the sequencer index to all-ones.
- `full` and `empty` lag the causing write or pop by exactly one edge.

## Configuration
- `UART_TX_B2B_EN`:
  - Defined: the SEND frame-end path reloads directly into ARM when `~empty`; frames are contiguous on the line.
  - Undefined: SEND always goes to IDLE at frame end. Every frame is separated by at least one cycle of `tx_en`=0 plus the sequencer's restart cycle.

## Test plan
- Reset: assert `arst_n`=0 mid-ARM → next cycle `tx_en`=0, `count`=0, `empty`=1, `overflow`=0; same check using `rst`=1.
- Single byte: write 0xA5 with `empty`=1 → `tx_en`=1 and `tx_data`=0xA5 two cycles later. Drive `tx_busy`=1, then `tx_done` 0→1 → `tx_en`=0 next cycle, `empty`=1.
- Fill/overflow: write 0x01..0x05 on consecutive cycles with no pop (DEPTH=4) → `full`=1, `count`=4, `overflow`=1; FIFO holds 0x01..0x04. Write plus pop while full → `count` stays 4 and `overflow` does not re-trigger.
- Back-to-back with `UART_TX_B2B_EN`: queue 0x11, 0x22, 0x33 → `tx_en` held high across all three frames; `tx_data` changes only on each `tx_done` rise. Without the macro → `tx_en` is low for exactly 1 cycle between frames.
- Pointer wrap: 10 write/send cycles at DEPTH=4 → bytes emerge in write order, `count` returns to 0.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// ============================================================================
// Module : uart_tx_feeder_if
// Host write port and sequencer handshake bundle for uart_tx_feeder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  tx_en;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, tx_busy, tx_done,
    input  tx_en, tx_data, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, tx_done,
    output tx_en, tx_data, full, empty, count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ============================================================================
// Module : uart_tx_feeder
// Byte FIFO plus framing FSM feeding the UART bit sequencer.
// Option : define UART_TX_B2B_EN to chain queued frames without an idle gap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  uart_tx_feeder_if.slave   bus
);

`ifdef UART_TX_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  done_q;
  logic                  tx_en_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  overflow_q;

  logic                  full;
  logic                  empty;
  logic                  done_rise;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign done_rise = ~done_q & bus.tx_done;
  // A pop in the same cycle frees a slot, so a write while full is still taken.
  assign push      = bus.wr_en & (~full | pop);
  assign drop      = bus.wr_en & full & ~pop;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (bus.tx_busy) state_nxt = SEND;
      end
      SEND: begin
        if (done_rise) begin
          if (B2B && !empty) begin
            pop       = 1'b1;
            state_nxt = ARM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      done_q     <= 1'b1;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (rst) begin
      done_q     <= 1'b1;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q  <= bus.tx_done;
      tx_en_q <= (state_nxt != IDLE);
      if (pop)  tx_data_q <= mem[rd_ptr];
      if (push) wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
      if (push && !pop)      count_q <= count_q + (ADDR_WIDTH+1)'(1);
      else if (pop && !push) count_q <= count_q - (ADDR_WIDTH+1)'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

`default_nettype wire
